// File: rtl/saida_pkg.sv
// Shared types, constants and helpers for the saida_display result viewer.
// Segment patterns are active-low, bit order gfedcba.
package saida_pkg;

  localparam int BCD_DIGITS  = 10;
  localparam int CONV_CYCLES = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    SHOW = 2'd2
  } state_t;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;

  // Double-dabble correction: every nibble >= 5 gets +3 before the shift.
  function automatic logic [4*BCD_DIGITS-1:0] dd_adjust(input logic [4*BCD_DIGITS-1:0] acc);
    logic [4*BCD_DIGITS-1:0] res;
    res = acc;
    for (int d = 0; d < BCD_DIGITS; d++) begin
      if (acc[4*d +: 4] >= 4'd5) begin
        res[4*d +: 4] = acc[4*d +: 4] + 4'd3;
      end else begin
        res[4*d +: 4] = acc[4*d +: 4];
      end
    end
    return res;
  endfunction

  function automatic logic [6:0] seg7_digit(input logic [3:0] d);
    case (d)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/saida_if.sv
// Datapath-to-display bus for saida_display; seg/seg_sign exist only
// when SAIDA_SEG7_EN is defined.
interface saida_if #(parameter int DEPTH = 8) ();
  logic                     wr_en;
  logic [31:0]              wr_data;
  logic                     next;
  logic                     full;
  logic [$clog2(DEPTH):0]   count;
  logic                     overflow;
  logic                     busy;
  logic                     valid;
  logic                     neg;
  logic [39:0]              bcd;
`ifdef SAIDA_SEG7_EN
  logic [69:0]              seg;
  logic [6:0]               seg_sign;
`endif

  modport slave (
    input  wr_en, wr_data, next,
    output full, count, overflow, busy, valid, neg, bcd
`ifdef SAIDA_SEG7_EN
    , output seg, seg_sign
`endif
  );

  modport master (
    output wr_en, wr_data, next,
    input  full, count, overflow, busy, valid, neg, bcd
`ifdef SAIDA_SEG7_EN
    , input seg, seg_sign
`endif
  );
endinterface

// File: rtl/saida_fifo.sv
// Result FIFO: DEPTH x DATA_W storage, occupancy count and sticky overflow.
// Full is judged on the registered count, so a same-cycle pop never frees room.
module saida_fifo #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_wr_en,
  input  logic [DATA_W-1:0]          i_wr_data,
  input  logic                       i_pop,
  output logic [DATA_W-1:0]          o_rd_data,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_count;
  logic              r_overflow;
  logic              w_wr_ok;
  logic              w_rd_ok;

  assign w_wr_ok = i_wr_en && (r_count != FULL_CNT);
  assign w_rd_ok = i_pop && (r_count != '0);

  always_ff @(posedge clk) begin
    if (w_wr_ok) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd_ok) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + (AW+1)'(w_wr_ok) - (AW+1)'(w_rd_ok);
      if (i_wr_en && !w_wr_ok) r_overflow <= 1'b1;
    end
  end

  assign o_rd_data  = r_mem[r_rd_ptr];
  assign o_full     = (r_count == FULL_CNT);
  assign o_empty    = (r_count == '0);
  assign o_count    = r_count;
  assign o_overflow = r_overflow;
endmodule

// File: rtl/saida_display.sv
// Buffers signed results and shows them one at a time as sign + 10 BCD digits.
// Optional 7-segment outputs are enabled with SAIDA_SEG7_EN.
module saida_display
  import saida_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 32
) (
  input  logic    clk,
  input  logic    reset,
  saida_if.slave  bus
);
  localparam int ACC_W = 4 * BCD_DIGITS;

  state_t              r_state;
  logic                r_next_prev;
  logic [ACC_W-1:0]    r_acc;
  logic [DATA_W-1:0]   r_mag;
  logic [5:0]          r_iter;
  logic                r_sign;
  logic                r_busy;
  logic                r_valid;
  logic                r_neg;
  logic [ACC_W-1:0]    r_bcd;

  logic [DATA_W-1:0]   w_head;
  logic [DATA_W-1:0]   w_head_mag;
  logic                w_empty;
  logic                w_pop;
  logic                w_adv;
  logic [ACC_W-1:0]    w_acc_adj;
  logic [ACC_W-1:0]    w_acc_next;
  logic [DATA_W-1:0]   w_mag_next;

  saida_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .i_wr_en    (bus.wr_en),
    .i_wr_data  (bus.wr_data),
    .i_pop      (w_pop),
    .o_rd_data  (w_head),
    .o_full     (bus.full),
    .o_empty    (w_empty),
    .o_count    (bus.count),
    .o_overflow (bus.overflow)
  );

  assign w_adv      = bus.next && !r_next_prev;
  // -2^31 negates to itself, which is the correct unsigned magnitude.
  assign w_head_mag = w_head[DATA_W-1] ? (~w_head + DATA_W'(1)) : w_head;
  assign w_acc_adj  = dd_adjust(r_acc);
  assign {w_acc_next, w_mag_next} = {w_acc_adj[ACC_W-2:0], r_mag, 1'b0};

  // Pop the head when idle, or when an advance lands on a completed display.
  always_comb begin
    w_pop = 1'b0;
    case (r_state)
      IDLE:    w_pop = !w_empty;
      SHOW:    w_pop = r_valid && w_adv && !w_empty;
      default: w_pop = 1'b0;
    endcase
  end

  // Display FSM with the shift-add-3 converter; the first SHOW cycle loads bcd/neg.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_next_prev <= 1'b0;
      r_acc       <= '0;
      r_mag       <= '0;
      r_iter      <= '0;
      r_sign      <= 1'b0;
      r_busy      <= 1'b0;
      r_valid     <= 1'b0;
      r_neg       <= 1'b0;
      r_bcd       <= '0;
    end else begin
      r_next_prev <= bus.next;
      case (r_state)
        IDLE: begin
          r_valid <= 1'b0;
          r_neg   <= 1'b0;
          r_bcd   <= '0;
          if (w_pop) begin
            r_sign  <= w_head[DATA_W-1];
            r_mag   <= w_head_mag;
            r_acc   <= '0;
            r_iter  <= '0;
            r_busy  <= 1'b1;
            r_state <= CONV;
          end
        end
        CONV: begin
          r_acc  <= w_acc_next;
          r_mag  <= w_mag_next;
          r_iter <= r_iter + 6'd1;
          if (r_iter == 6'(CONV_CYCLES - 1)) begin
            r_busy  <= 1'b0;
            r_state <= SHOW;
          end
        end
        SHOW: begin
          if (!r_valid) begin
            r_valid <= 1'b1;
            r_bcd   <= r_acc;
            r_neg   <= r_sign;
          end else if (w_adv) begin
            r_valid <= 1'b0;
            r_neg   <= 1'b0;
            r_bcd   <= '0;
            if (w_pop) begin
              r_sign  <= w_head[DATA_W-1];
              r_mag   <= w_head_mag;
              r_acc   <= '0;
              r_iter  <= '0;
              r_busy  <= 1'b1;
              r_state <= CONV;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.busy  = r_busy;
  assign bus.valid = r_valid;
  assign bus.neg   = r_neg;
  assign bus.bcd   = r_bcd;

`ifdef SAIDA_SEG7_EN
  for (genvar d = 0; d < BCD_DIGITS; d++) begin : g_seg
    assign bus.seg[7*d +: 7] = r_valid ? seg7_digit(r_bcd[4*d +: 4]) : SEG_BLANK;
  end
  assign bus.seg_sign = (r_neg && r_valid) ? SEG_MINUS : SEG_BLANK;
`endif
endmodule

// File: tb/tb_saida_display.sv
// Directed bench for saida_display: scoreboard of expected {neg,bcd} per written
// value, compared when each value becomes valid.
module tb_saida_display;
  localparam int DEPTH = 8;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad   = 0;
  logic [40:0] sb[$];

  saida_if #(.DEPTH(DEPTH)) bus ();

  saida_display #(.DEPTH(DEPTH), .DATA_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference conversion by repeated division, independent of double-dabble.
  function automatic logic [40:0] model(input logic [31:0] v);
    logic [32:0] m;
    logic [39:0] b;
    m = v[31] ? ({1'b0, ~v} + 33'd1) : {1'b0, v};
    for (int d = 0; d < 10; d++) begin
      b[4*d +: 4] = 4'(m % 33'd10);
      m = m / 33'd10;
    end
    return {v[31], b};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [31:0] v, input bit accept);
    bus.wr_en   = 1'b1;
    bus.wr_data = v;
    if (accept) sb.push_back(model(v));
    tick();
    bus.wr_en   = 1'b0;
  endtask

  task automatic check_sb(input string tag);
    logic [40:0] e;
    e = '1;
    if (sb.size() > 0) e = sb.pop_front();
    chk(tag, 64'({bus.neg, bus.bcd}), 64'(e));
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!bus.valid && n < 200) begin
      tick();
      n++;
    end
    chk({tag, "_seen"}, 64'(bus.valid), 64'd1);
    check_sb(tag);
  endtask

  task automatic advance();
    bus.next = 1'b1;
    tick();
    bus.next = 1'b0;
  endtask

  initial begin
    int edges;
    int busy_cnt;
    bus.wr_en   = 1'b0;
    bus.wr_data = 32'd0;
    bus.next    = 1'b0;
    reset       = 1'b1;
    tick();
    tick();
    chk("rst_count", 64'(bus.count), 64'd0);
    chk("rst_full", 64'(bus.full), 64'd0);
    chk("rst_ovf", 64'(bus.overflow), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_valid", 64'(bus.valid), 64'd0);
    chk("rst_neg_bcd", 64'({bus.neg, bus.bcd}), 64'd0);
    reset = 1'b0;
    tick();

    // Latency from the write edge to valid, and conversion duration.
    wr(32'd12345, 1'b1);
    edges    = 0;
    busy_cnt = 0;
    while (!bus.valid && edges < 100) begin
      tick();
      edges++;
      if (bus.busy) busy_cnt++;
    end
    chk("t1_latency", 64'(edges), 64'd34);
    chk("t1_busy_cycles", 64'(busy_cnt), 64'd32);
    check_sb("t1_val");
    chk("t1_bcd_const", 64'({bus.neg, bus.bcd}), 64'h0000012345);

    // Negative values including the most negative one.
    wr(32'hFFFF_FFFF, 1'b1);
    wr(32'h8000_0000, 1'b1);
    advance();
    wait_valid("t2_m1");
    chk("t2_m1_const", 64'({bus.neg, bus.bcd}), 64'h100_0000_0001);
    advance();
    wait_valid("t2_min");
    chk("t2_min_const", 64'({bus.neg, bus.bcd}), 64'h121_4748_3648);

    // Unsigned 4294967295 reads as -1; largest positive; zero.
    wr(32'd4294967295, 1'b1);
    wr(32'd2147483647, 1'b1);
    wr(32'd0, 1'b1);
    advance();
    wait_valid("t3_ffff");
    advance();
    wait_valid("t3_max");
    chk("t3_max_const", 64'({bus.neg, bus.bcd}), 64'h021_4748_3647);
    advance();
    wait_valid("t3_zero");
    advance();
    tick();
    tick();
    chk("t3_idle_valid", 64'(bus.valid), 64'd0);
    chk("t3_idle_bcd", 64'({bus.neg, bus.bcd}), 64'd0);
    chk("t3_idle_busy", 64'(bus.busy), 64'd0);

    // Fill while a value is shown: 8 accepted, 9th dropped.
    wr(32'd100, 1'b1);
    wait_valid("t4_100");
    for (int i = 1; i <= 9; i++) begin
      wr(32'(i), (i <= 8));
      if (i == 8) begin
        chk("t4_full8", 64'(bus.full), 64'd1);
        chk("t4_count8", 64'(bus.count), 64'd8);
        chk("t4_ovf_before", 64'(bus.overflow), 64'd0);
      end
    end
    chk("t4_ovf", 64'(bus.overflow), 64'd1);
    chk("t4_count_after", 64'(bus.count), 64'd8);
    for (int i = 1; i <= 8; i++) begin
      advance();
      wait_valid("t4_step");
    end
    chk("t4_empty_count", 64'(bus.count), 64'd0);
    advance();
    tick();
    chk("t4_idle_valid", 64'(bus.valid), 64'd0);
    chk("t4_ovf_sticky", 64'(bus.overflow), 64'd1);

    // Held button advances once; an edge during conversion is ignored.
    wr(32'd10, 1'b1);
    wr(32'd20, 1'b1);
    wr(32'd30, 1'b1);
    wr(32'd40, 1'b1);
    wait_valid("t5_10");
    chk("t5_count3", 64'(bus.count), 64'd3);
    bus.next = 1'b1;
    repeat (100) tick();
    chk("t5_hold_count", 64'(bus.count), 64'd2);
    check_sb("t5_20");
    bus.next = 1'b0;
    tick();
    advance();
    repeat (5) tick();
    chk("t5_busy_mid", 64'(bus.busy), 64'd1);
    advance();
    wait_valid("t5_30");
    chk("t5_count1", 64'(bus.count), 64'd1);
    repeat (40) tick();
    chk("t5_still_valid", 64'(bus.valid), 64'd1);
    chk("t5_still_count", 64'(bus.count), 64'd1);

    // Reset in the middle of a conversion with two entries queued.
    wr(32'd50, 1'b1);
    wr(32'd60, 1'b1);
    advance();
    repeat (15) tick();
    chk("t6_busy_pre", 64'(bus.busy), 64'd1);
    chk("t6_count_pre", 64'(bus.count), 64'd2);
    reset = 1'b1;
    tick();
    chk("t6_count", 64'(bus.count), 64'd0);
    chk("t6_valid", 64'(bus.valid), 64'd0);
    chk("t6_busy", 64'(bus.busy), 64'd0);
    chk("t6_bcd", 64'({bus.neg, bus.bcd}), 64'd0);
    chk("t6_ovf", 64'(bus.overflow), 64'd0);
    sb.delete();
    reset = 1'b0;
    repeat (50) tick();
    chk("t6_no_conv_busy", 64'(bus.busy), 64'd0);
    chk("t6_no_conv_valid", 64'(bus.valid), 64'd0);
    chk("t6_no_conv_count", 64'(bus.count), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/saida_display.md
Name: saida_display

Overview:
- Output-side counterpart of the switch-input stack: the datapath pushes 32-bit signed results into this block instead of pulling operands from switches.
- Values are buffered in a FIFO and shown one at a time in the order written.
- Each value is converted to sign plus 10 BCD digits by a sequential shift-add-3 (double-dabble) engine.
- The user steps to the next value with a push-button.

Parameters:
- DEPTH, 8, FIFO entries; power of two, at least 2.
- DATA_W, 32, data width; fixed at 32, BCD sizing depends on it.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high; clock clk.
- wr_en  in  1  write strobe from datapath.
- wr_data  in  32  two's-complement value to display.
- next  in  1  push-button level (already synchronized), advances display.
- full  out  1  FIFO holds DEPTH entries.
- count  out  $clog2(DEPTH)+1  entries waiting in FIFO (excludes shown value).
- overflow  out  1  sticky; write attempted while full.
- busy  out  1  conversion in progress.
- valid  out  1  bcd/neg hold a completed value.
- neg  out  1  shown value is negative.
- bcd  out  40  10 BCD digits, digit 0 in [3:0].

Behaviour:
- Reset: FIFO emptied (count=0), full=0, overflow=0, busy=0, valid=0, neg=0, bcd=0, FSM=IDLE, next edge register=0. Reset mid-conversion aborts it and discards all buffered data.
- FIFO:
  - Write accepted iff wr_en && !full, using full as sampled at the start of the cycle (a same-cycle pop does not make room).
  - Write while full: data dropped, overflow set until reset.
  - count updates next cycle by (+accepted write −pop).
  - Pointers wrap modulo DEPTH.
- next: registered; a rising edge (next=1, prev=0) produces a one-cycle advance pulse. Holding next high yields exactly one advance.
- FSM:
  - IDLE: valid=0, bcd=0, neg=0. If count>0: pop head, neg←head[31], mag←|head| (−2^31 maps to 2^31 unsigned), BCD accumulator←0, iter←0, go CONV.
  - CONV: busy=1. Each cycle, add 3 to every accumulator nibble ≥5, then shift {acc,mag} left by 1. iter increments; after the 32nd shift go SHOW. Advance pulses during CONV are discarded.
  - SHOW: valid=1, bcd/neg registered and stable. On an advance pulse: if count>0, pop and go CONV directly (valid drops the following cycle); else go IDLE.
- Latency: a write into an empty FIFO with FSM in IDLE gives valid=1 after the 34th rising edge following the edge that sampled wr_en (1 pop edge, 32 shift edges, 1 SHOW load edge).
- Writes may arrive on any cycle, including during CONV and SHOW. A simultaneous write and pop are both honored.
- Zero displays as all-zero bcd with neg=0; leading-zero suppression is not done here.

Optional Feature:
- Macro SAIDA_SEG7_EN.
- Defined: adds output seg[69:0], 7 bits per digit (active-low, gfedcba). Each digit is decoded combinationally from bcd, so seg tracks bcd with no added latency. Adds output seg_sign[6:0], showing '-' when neg && valid and blank otherwise. All segments are blank while valid=0.
- Undefined: the seg and seg_sign ports do not exist; all other behaviour is identical.

Decomposition:
- Package saida_pkg holds:
  - BCD_DIGITS=10
  - CONV_CYCLES=32
  - state typedef {IDLE, CONV, SHOW}
  - 7-segment digit constants and the SEG_BLANK and SEG_MINUS patterns
- Sub-module saida_fifo: DEPTH×32 storage with wr/rd pointers, count, full/empty and the overflow flag. The FSM, converter and segment decode stay in the top module.

Test Plan:
- Write 12345 once from reset → busy for 32 cycles; valid=1 exactly 34 edges after the write; bcd=40'h0000012345, neg=0.
- Write −1, then 0x80000000; pulse next after the first is shown → first gives neg=1, bcd=1; second gives neg=1, bcd=40'h2147483648.
- Write 4294967295 interpreted as −1 versus 2147483647 → verifies 2147483647 yields bcd=40'h2147483647, neg=0.
- Write 9 values back-to-back while the FSM is held in SHOW → full=1 after the 8th, 9th dropped, overflow=1; stepping with next shows values 1..8 in order, then IDLE with valid=0.
- Hold next high for 100 cycles during SHOW with 3 entries queued → exactly one advance; an edge during CONV is ignored.
- Assert reset at iter=15 of CONV with 2 entries queued → next cycle count=0, valid=0, busy=0, bcd=0; no further conversion starts.
